// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
// Shared bank of WIDTH JK bits written by NREQ requesters. A round-robin
// arbiter picks one request at a time; the winner's {j,k} code and bit mask
// are latched and applied to the bank one cycle later. At most one operation
// is applied per grant, so a grant always takes two cycles (IDLE -> GRANT).
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   req   in   [NREQ]        per-requester request, held until granted
//   op    in   [2*NREQ]      per-requester {j,k}: 00 hold 01 clear 10 set 11 toggle
//   mask  in   [WIDTH*NREQ]  per-requester bit select, 1 = bit affected
//   gnt   out  [NREQ]        one-hot grant, one cycle per accepted request
//   q     out  [WIDTH]       JK bank state
//   done  out  1             pulse in the cycle after q reflects an operation
//   busy  out  1             high while in GRANT
// -----------------------------------------------------------------------------
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      op,
    input  logic [WIDTH*NREQ-1:0]  mask,
    output logic [NREQ-1:0]        gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   done,
    output logic                   busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_win;
    logic [1:0]          r_op;
    logic [WIDTH-1:0]    r_mask;
    logic [WIDTH-1:0]    r_q;
    logic [NREQ-1:0]     r_gnt;
    logic                r_done;
    logic                r_busy;

    logic                w_any;
    logic [PW-1:0]       w_win;
    logic [PW-1:0]       w_ptr_nxt;
    logic [NREQ-1:0]     w_gnt_onehot;

    // First requester with req=1 scanning ptr, ptr+1, ... with wrap-around.
    // Returns {found, index}.
    function automatic logic [PW:0] pick_winner(
        input logic [NREQ-1:0] f_req,
        input logic [PW-1:0]   f_ptr
    );
        logic          found;
        logic [PW-1:0] win;
        int            idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(f_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && f_req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // Apply one JK code to every masked bit; unmasked bits keep their value.
    function automatic logic [WIDTH-1:0] jk_apply(
        input logic [WIDTH-1:0] f_q,
        input logic [1:0]       f_op,
        input logic [WIDTH-1:0] f_mask
    );
        logic [WIDTH-1:0] res;
        res = f_q;
        for (int b = 0; b < WIDTH; b++) begin
            if (f_mask[b]) begin
                case (f_op)
                    2'b00:   res[b] = f_q[b];
                    2'b01:   res[b] = 1'b0;
                    2'b10:   res[b] = 1'b1;
                    2'b11:   res[b] = ~f_q[b];
                    default: res[b] = f_q[b];
                endcase
            end else begin
                res[b] = f_q[b];
            end
        end
        return res;
    endfunction

    // Arbitration: winner, its one-hot grant and the pointer after this grant.
    always_comb begin
        {w_any, w_win} = pick_winner(req, r_ptr);
        w_gnt_onehot   = NREQ'(1) << w_win;
        if (r_win == PW'(NREQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = r_win + PW'(1);
        end
    end

    // Next-state logic: leave IDLE on any request, GRANT always lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: latch the winner in IDLE, apply its op and advance ptr in GRANT.
    // Inputs are only sampled in IDLE, so changes during GRANT cannot leak in;
    // reset discards a latched op before it reaches q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_win  <= '0;
            r_op   <= 2'b00;
            r_mask <= '0;
            r_q    <= '0;
            r_gnt  <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_any) begin
                        r_win  <= w_win;
                        r_op   <= op[2*int'(w_win) +: 2];
                        r_mask <= mask[WIDTH*int'(w_win) +: WIDTH];
                        r_gnt  <= w_gnt_onehot;
                        r_busy <= 1'b1;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    r_q    <= jk_apply(r_q, r_op, r_mask);
                    r_ptr  <= w_ptr_nxt;
                    r_gnt  <= '0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                    r_gnt  <= '0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign q    = r_q;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter (NREQ=4, WIDTH=8). The stimulus side
// predicts, from the arbitration rules, the order in which a batch of pending
// requests is granted and the bank value after each one, and queues those
// expectations; an independent monitor pops them as grants appear.
module tb_jk_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] mask;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  done;
    logic                  busy;

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .op   (op),
        .mask (mask),
        .gnt  (gnt),
        .q    (q),
        .done (done),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0]  g;
        logic [WIDTH-1:0] qv;
    } exp_t;

    exp_t             exp_q[$];
    logic [NREQ-1:0]  gnt_log[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic             sb_off = 1'b0;

    // reference model state
    logic [WIDTH-1:0] m_q   = '0;
    int               m_ptr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_op(input logic [WIDTH-1:0] cur,
                                                 input logic [1:0] code,
                                                 input logic [WIDTH-1:0] m);
        case (code)
            2'b01:   return cur & ~m;
            2'b10:   return cur | m;
            2'b11:   return cur ^ m;
            default: return cur;
        endcase
    endfunction

    // Issue a batch of simultaneous requests (called at a negedge while idle),
    // predict the full grant order, then serve grants like a well-behaved
    // requester: drop req after seeing gnt and scribble over op/mask, which
    // the DUT must ignore.
    task automatic run_batch(input logic [NREQ-1:0] set,
                             input logic [2*NREQ-1:0] ops,
                             input logic [WIDTH*NREQ-1:0] masks);
        logic [NREQ-1:0] pend;
        int win;
        int cyc;
        pend = set;
        while (pend != '0) begin
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && pend[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
            m_q = model_op(m_q, ops[2*win +: 2], masks[WIDTH*win +: WIDTH]);
            exp_q.push_back('{g: NREQ'(1) << win, qv: m_q});
            pend[win] = 1'b0;
            m_ptr = (win + 1) % NREQ;
        end
        op   = ops;
        mask = masks;
        req  = set;
        cyc  = 0;
        while (req != '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    req[i] = 1'b0;
                    op[2*i +: 2] = 2'b01;
                    mask[WIDTH*i +: WIDTH] = {WIDTH{1'b1}};
                end
            end
        end
        if (cyc >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL batch_timeout: req still %b expected 0", req);
            req = '0;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: pops an expectation per grant and checks the done/q that follow.
    logic             pend_chk = 1'b0;
    logic [WIDTH-1:0] chk_q    = '0;
    logic [NREQ-1:0]  prev_gnt = '0;
    exp_t             e;
    always @(negedge clk) begin
        if (rst || sb_off) begin
            pend_chk = 1'b0;
            prev_gnt = '0;
        end else begin
            check("done_pulse", 32'(done), 32'(pend_chk));
            if (pend_chk && done) check("q_after_op", 32'(q), 32'(chk_q));
            pend_chk = 1'b0;
            if (gnt != '0) begin
                check("gnt_not_back_to_back", 32'(prev_gnt), 32'd0);
                check("busy_in_grant", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt_order", 32'(gnt), 32'(e.g));
                    chk_q    = e.qv;
                    pend_chk = 1'b1;
                end
                gnt_log.push_back(gnt);
            end else begin
                check("busy_idle", 32'(busy), 32'd0);
            end
            prev_gnt = gnt;
        end
    end

    task automatic check_log(input string name, input int idx, input logic [NREQ-1:0] expv);
        if (gnt_log.size() <= idx) check(name, 32'(gnt_log.size()), 32'(idx + 1));
        else check(name, 32'(gnt_log[idx]), 32'(expv));
    endtask

    initial begin
        int cyc;
        rst  = 1'b1;
        req  = '0;
        op   = '0;
        mask = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {q, gnt, done, busy}, 32'd0);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_outputs", {q, gnt, done, busy}, 32'd0);
        end

        // one op per code from requester 0
        run_batch(4'b0001, 8'b10, 32'h0F);
        check("set_0F", 32'(q), 32'h0F);
        run_batch(4'b0001, 8'b11, 32'hFF);
        check("toggle_F0", 32'(q), 32'hF0);
        run_batch(4'b0001, 8'b01, 32'h30);
        check("clear_C0", 32'(q), 32'hC0);
        run_batch(4'b0001, 8'b00, 32'hFF);
        check("hold_C0", 32'(q), 32'hC0);
        run_batch(4'b0001, 8'b11, 32'h65);
        check("toggle_A5", 32'(q), 32'hA5);

        // asynchronous reset between edges
        #2 rst = 1'b1;
        #1 check("async_reset", {q, gnt, done, busy}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        m_q   = '0;
        m_ptr = 0;
        repeat (10) begin
            @(negedge clk);
            check("idle_after_reset", {q, gnt, done, busy}, 32'd0);
        end

        // round robin, every requester toggles its own bit, two rounds
        gnt_log.delete();
        run_batch(4'b1111, 8'hFF, 32'h08040201);
        check_log("rr0", 0, 4'b0001);
        check_log("rr1", 1, 4'b0010);
        check_log("rr2", 2, 4'b0100);
        check_log("rr3", 3, 4'b1000);
        check("rr_q_0F", 32'(q), 32'h0F);
        run_batch(4'b1111, 8'hFF, 32'h08040201);
        check_log("rr4", 4, 4'b0001);
        check("rr_q_00", 32'(q), 32'h00);

        // wrap: after requester 2, {1,0} pending -> 0 then 1
        run_batch(4'b0100, 8'h00, 32'hFFFFFFFF);
        gnt_log.delete();
        run_batch(4'b0011, 8'h00, 32'hFFFFFFFF);
        check_log("wrap_first", 0, 4'b0001);
        check_log("wrap_second", 1, 4'b0010);

        // op/mask rewritten during GRANT must be ignored
        run_batch(4'b0010, 8'b1000, 32'h00000100);
        check("midgrant_ignore", 32'(q), 32'h01);

        // reset during GRANT aborts the op; ptr (currently 2) returns to 0
        sb_off = 1'b1;
        op   = 8'b10000000;
        mask = 32'hFF000000;
        req  = 4'b1000;
        cyc  = 0;
        while (gnt[3] !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_grant_seen", 32'(gnt), 32'h8);
        #1 rst = 1'b1;
        req = '0;
        #1 check("abort_reset_outputs", {q, gnt, done, busy}, 32'd0);
        @(negedge clk);
        check("abort_no_done", {q, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_op_dropped", {q, done}, 32'd0);
        m_q   = '0;
        m_ptr = 0;
        sb_off = 1'b0;
        gnt_log.delete();
        run_batch(4'b1010, 8'b10001000, 32'h80000800);
        check_log("ptr_reset_first", 0, 4'b0010);
        check_log("ptr_reset_second", 1, 4'b1000);

        // random batches
        for (int t = 0; t < 40; t++) begin
            run_batch(4'($urandom_range(1, 15)), 8'($urandom), $urandom);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Shared bank of WIDTH JK flip-flop bits, updated by NREQ independent requesters through a round-robin arbiter. Each granted request applies one JK operation (hold/clear/set/toggle) to the bits selected by its mask. At most one operation is applied per grant. The block sits between control agents and the JK state bits they share, and serialises every write to that bank.

## Interface
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, number of JK bits in the bank (1..32)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request; held high until its gnt bit is seen
- op  in  2*NREQ  per-requester {j,k} code, slice [2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle
- mask  in  WIDTH*NREQ  per-requester bit select, slice [WIDTH*i +: WIDTH]; 1 = bit affected
- gnt  out  NREQ  one-hot grant, high for exactly one cycle per accepted request
- q  out  WIDTH  JK bank state
- done  out  1  one-cycle pulse the cycle after q reflects a granted operation
- busy  out  1  high while in GRANT state

## Operation
- Reset: q=0, gnt=0, done=0, busy=0, state=IDLE, round-robin pointer ptr=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - At a clock edge with any req bit high, select the winner: the first requester with req=1 at index ptr, ptr+1, … NREQ-1, 0, … (wrap-around).
  - Latch the winner index, its op slice and its mask slice, and go to GRANT.
  - With no req bit high, stay in IDLE.
- GRANT: gnt[winner]=1 and busy=1. At the next edge:
  - For each bit b with latched mask[b]=1: op 00 keeps q[b], 01 sets q[b]=0, 10 sets q[b]=1, 11 sets q[b]=~q[b]. Bits with mask=0 keep their value.
  - Set ptr=(winner+1) mod NREQ, assert done for the following cycle, and return to IDLE.
- req, op and mask are sampled only in IDLE. Changes while in GRANT are ignored for the operation in flight.
- A requester that sees gnt high must drop req in the next cycle. If req is still high on the next IDLE edge, it counts as a new request and competes under the advanced ptr.
- A requester that drops req before it is granted withdraws its request without error.
- mask=0 or op=00 still completes a full grant: gnt and done pulse, q unchanged.
- rst asserted at any time, including during GRANT, aborts the operation in flight. The latched op is not applied and all outputs return to reset values immediately.

## Timing
- Edge E0 (IDLE, req seen) → gnt and busy high during cycle E0..E1 → q updated at E1 → done high during cycle E1..E2.
- Request-to-q latency is 2 edges. Throughput is one operation per 2 cycles per bank.
- Back-to-back operations: E1 returns to IDLE, and if a req is pending, the next winner is latched at E2. gnt is therefore never high in two consecutive cycles.
- q, gnt, done and busy are registered outputs with no combinational path from req, op or mask.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,…,NREQ-1,0. Any requester waits at most NREQ grants.

## Test plan
- Reset and idle: assert rst mid-simulation with q=8'hA5 → q=0, gnt=0, done=0, busy=0 asynchronously. With no req after release, outputs stay 0 for 10 cycles.
- Single op per code (NREQ=4, WIDTH=8), starting from q=8'h00:
  - req0 set, mask=8'h0F → q=8'h0F two edges later, gnt=4'b0001 for one cycle, done one cycle after.
  - Then toggle, mask=8'hFF → q=8'hF0.
  - Then clear, mask=8'h30 → q=8'hC0.
  - Then hold, mask=8'hFF → q=8'hC0, done still pulses.
- Round-robin: req=4'b1111 held continuously, ops all toggle on distinct single bits → gnt sequence 0001, 0010, 0100, 1000, 0001, one every 2 cycles, each bit toggling once per round.
- Wrap and pointer: after granting requester 2, assert req=4'b0011 → requester 0 is granted first (wrap), then requester 1.
- Ignored mid-GRANT change: during GRANT for req1 (set, mask=8'h01), drive op1=clear and mask1=8'hFF → only q[0] set, other bits unchanged.
- Reset mid-operation: assert rst during the GRANT cycle of a set on mask=8'hFF → q=0 after reset, no done pulse. The first request after release is arbitrated with ptr=0.
